// File: rtl/mdu_pkg.sv
// Shared MDU op codes, latencies and decode helpers.
// Imported by the MDU and by its issue controller.
package mdu_pkg;

  typedef logic [3:0] mdu_op_t;

  localparam mdu_op_t MDU_NONE  = 4'd0;
  localparam mdu_op_t MDU_MFHI  = 4'd1;
  localparam mdu_op_t MDU_MFLO  = 4'd2;
  localparam mdu_op_t MDU_MTHI  = 4'd3;
  localparam mdu_op_t MDU_MTLO  = 4'd4;
  localparam mdu_op_t MDU_MULT  = 4'd5;
  localparam mdu_op_t MDU_MULTU = 4'd6;
  localparam mdu_op_t MDU_DIV   = 4'd7;
  localparam mdu_op_t MDU_DIVU  = 4'd8;

  localparam int MDU_MUL_LAT = 5;
  localparam int MDU_DIV_LAT = 10;

  typedef enum logic {
    SH_IDLE,
    SH_RUN
  } sh_state_t;

  function automatic logic is_mdu_op(input mdu_op_t op);
    return (op >= MDU_MFHI) && (op <= MDU_DIVU);
  endfunction

  function automatic logic is_start_op(input mdu_op_t op);
    return (op >= MDU_MULT) && (op <= MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_issue_ctrl_if.sv
// Pipeline/MDU-side bundle of the MDU issue controller.
// slave = controller view, master = pipeline + MDU view.
interface mdu_issue_ctrl_if;
  import mdu_pkg::*;

  logic    d_valid;
  mdu_op_t d_mdu_op;
  logic    e_valid;
  mdu_op_t e_mdu_op;
  logic    e_hold;
  logic    req;
  logic    mdu_busy;
  mdu_op_t mdu_ctrl;
  logic    mdu_start;
  logic    stall_d;
  logic    shadow_busy;
  logic    mdu_done;
  logic    busy_mismatch;

  modport slave (
    input  d_valid, d_mdu_op,
    input  e_valid, e_mdu_op,
    input  e_hold, req, mdu_busy,
    output mdu_ctrl, mdu_start,
    output stall_d, shadow_busy,
    output mdu_done, busy_mismatch
  );

  modport master (
    output d_valid, d_mdu_op,
    output e_valid, e_mdu_op,
    output e_hold, req, mdu_busy,
    input  mdu_ctrl, mdu_start,
    input  stall_d, shadow_busy,
    input  mdu_done, busy_mismatch
  );

endinterface

// File: rtl/mdu_shadow_cnt.sv
// Shadow model of MDU busy: IDLE/RUN FSM, latency counter,
// done pulse and sticky cross-check against the real MDU busy.
module mdu_shadow_cnt
  import mdu_pkg::*;
#(
  parameter int MUL_LAT = MDU_MUL_LAT,
  parameter int DIV_LAT = MDU_DIV_LAT,
  parameter int CNT_W   = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_start,
  input  logic i_is_div,
  input  logic i_req,
  input  logic i_mdu_busy,
  output logic o_busy,
  output logic o_done,
  output logic o_mismatch
);

  sh_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_mis, w_mis_nxt;
  logic [CNT_W-1:0] w_lat;

  assign w_lat = i_is_div ? CNT_W'(DIV_LAT)
                          : CNT_W'(MUL_LAT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= SH_IDLE;
      r_cnt   <= '0;
      r_mis   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_mis   <= w_mis_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_done      = 1'b0;
    w_mis_nxt   = r_mis | (o_busy != i_mdu_busy);
    unique case (r_state)
      SH_IDLE: begin
        if (i_start) begin
          w_state_nxt = SH_RUN;
          w_cnt_nxt   = w_lat;
        end
      end
      SH_RUN: begin
        // MDU reloads on a stray start; follow it but flag it
        if (i_start) begin
          w_cnt_nxt = w_lat;
          w_mis_nxt = 1'b1;
        end else if (!i_req) begin
          w_cnt_nxt = r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) begin
            w_state_nxt = SH_IDLE;
            o_done      = 1'b1;
          end
        end
      end
      default: w_state_nxt = SH_IDLE;
    endcase
  end

  assign o_busy     = (r_state == SH_RUN);
  assign o_mismatch = r_mis;

endmodule

// File: rtl/mdu_issue_ctrl.sv
// E-stage MDU issue/hazard control with exactly-once start.
// MDU_PERF_CNT_EN adds perf_stall_cnt (stall_d cycle count).
module mdu_issue_ctrl
  import mdu_pkg::*;
#(
  parameter int MUL_LAT = MDU_MUL_LAT,
  parameter int DIV_LAT = MDU_DIV_LAT,
  parameter int CNT_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
`ifdef MDU_PERF_CNT_EN
  output logic [31:0]       perf_stall_cnt,
`endif
  mdu_issue_ctrl_if.slave   bus
);

  logic w_e_act;
  logic w_start;
  logic w_stall;
  logic w_sh_busy;
  logic r_issued;

  assign w_e_act = bus.e_valid && !bus.req
                && is_mdu_op(bus.e_mdu_op);
  assign w_start = w_e_act && !r_issued
                && is_start_op(bus.e_mdu_op);

  // start edge stalls D because MDU busy rises an edge later
  assign w_stall = bus.d_valid && is_mdu_op(bus.d_mdu_op)
                && (w_start || bus.mdu_busy || w_sh_busy);

  assign bus.mdu_ctrl    = w_e_act ? bus.e_mdu_op : MDU_NONE;
  assign bus.mdu_start   = w_start;
  assign bus.stall_d     = w_stall;
  assign bus.shadow_busy = w_sh_busy;

  always_ff @(posedge clk) begin
    if (reset || bus.req || !bus.e_hold)
      r_issued <= 1'b0;
    else if (w_start)
      r_issued <= 1'b1;
  end

  mdu_shadow_cnt #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT),
    .CNT_W   (CNT_W)
  ) u_shadow (
    .clk        (clk),
    .reset      (reset),
    .i_start    (w_start),
    .i_is_div   (bus.e_mdu_op >= MDU_DIV),
    .i_req      (bus.req),
    .i_mdu_busy (bus.mdu_busy),
    .o_busy     (w_sh_busy),
    .o_done     (bus.mdu_done),
    .o_mismatch (bus.busy_mismatch)
  );

`ifdef MDU_PERF_CNT_EN
  logic [31:0] r_perf;

  always_ff @(posedge clk) begin
    if (reset)
      r_perf <= '0;
    else if (w_stall && !bus.req)
      r_perf <= r_perf + 32'd1;
  end

  assign perf_stall_cnt = r_perf;
`endif

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Bench for mdu_issue_ctrl: directed plan plus random traffic
// against a cycle-level reference model and a model MDU.
module tb_mdu_issue_ctrl;
  import mdu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mdu_issue_ctrl_if bus();

`ifdef MDU_PERF_CNT_EN
  logic [31:0] perf;
`endif

  mdu_issue_ctrl dut (
    .clk            (clk),
    .reset          (reset),
`ifdef MDU_PERF_CNT_EN
    .perf_stall_cnt (perf),
`endif
    .bus            (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(string tag, longint unsigned got,
                     longint unsigned exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d at %0t",
                  tag, got, exp, $time);
  endtask

  // reference model: remaining busy cycles (0 = idle)
  int      m_rem, m_mdu;
  bit      m_issued, m_mis;
  longint  m_perf;
  int      o_stall, o_busy, o_done, o_start;

  task automatic clr();
    o_stall = 0; o_busy = 0; o_done = 0; o_start = 0;
  endtask

  task automatic cyc(bit rst, bit dv, logic [3:0] dop,
                     bit ev, logic [3:0] eop, bit hold,
                     bit rq, bit fb = 1'b0);
    bit act, st, sb, dn, stl, mb;
    int lat;
    reset = rst;
    bus.d_valid = dv;   bus.d_mdu_op = dop;
    bus.e_valid = ev;   bus.e_mdu_op = eop;
    bus.e_hold  = hold; bus.req      = rq;
    mb = fb || (m_mdu > 0);
    bus.mdu_busy = mb;
    act = ev && eop >= 1 && eop <= 8 && !rq;
    st  = act && eop >= 5 && !m_issued;
    sb  = m_rem > 0;
    dn  = m_rem == 1 && !rq && !st;
    stl = dv && dop >= 1 && dop <= 8 && (st || mb || sb);
    #2;
    chk("ctrl",  bus.mdu_ctrl, act ? eop : 0);
    chk("start", bus.mdu_start, st);
    chk("stall", bus.stall_d, stl);
    chk("sbusy", bus.shadow_busy, sb);
    chk("done",  bus.mdu_done, dn);
    chk("mis",   bus.busy_mismatch, m_mis);
`ifdef MDU_PERF_CNT_EN
    chk("perf",  perf, m_perf);
`endif
    o_stall += int'(bus.stall_d);
    o_busy  += int'(bus.shadow_busy);
    o_done  += int'(bus.mdu_done);
    o_start += int'(bus.mdu_start);
    @(posedge clk);
    lat = (eop >= 7) ? 10 : 5;
    if (rst) begin
      m_rem = 0; m_mdu = 0; m_issued = 0;
      m_mis = 0; m_perf = 0;
    end else begin
      if (sb != mb || (st && sb)) m_mis = 1;
      if (stl && !rq) m_perf = (m_perf + 1) % (64'd1 << 32);
      if (st) m_rem = lat;
      else if (m_rem > 0 && !rq) m_rem--;
      if (st) m_mdu = lat;
      else if (m_mdu > 0 && !rq) m_mdu--;
      m_issued = (rq || !hold) ? 1'b0 : (st ? 1'b1 : m_issued);
    end
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1;
    bus.d_valid = 0; bus.d_mdu_op = 0;
    bus.e_valid = 0; bus.e_mdu_op = 0;
    bus.e_hold  = 0; bus.req      = 0;
    bus.mdu_busy = 0;
    m_rem = 0; m_mdu = 0; m_issued = 0; m_mis = 0; m_perf = 0;
    repeat (2) @(posedge clk);
    #1;
    cyc(1, 0, 0, 0, 0, 0, 0);
    idle(1);

    // mult in E, mfhi waiting in D
    clr();
    cyc(0, 1, MDU_MFHI, 1, MDU_MULT, 0, 0);
    repeat (7) cyc(0, 1, MDU_MFHI, 0, 0, 0, 0);
    chk("s1_stall", o_stall, 6);
    chk("s1_busy",  o_busy, 5);
    chk("s1_done",  o_done, 1);
    chk("s1_start", o_start, 1);

    // div held in E for three cycles
    clr();
    repeat (3) cyc(0, 0, 0, 1, MDU_DIV, 1, 0);
    cyc(0, 0, 0, 1, MDU_DIV, 0, 0);
    idle(12);
    chk("s2_start", o_start, 1);
    chk("s2_busy",  o_busy, 10);

    // divu frozen by req for two cycles
    clr();
    cyc(0, 0, 0, 1, MDU_DIVU, 0, 0);
    idle(3);
    repeat (2) cyc(0, 0, 0, 0, 0, 0, 1);
    idle(10);
    chk("s3_busy", o_busy, 12);
    chk("s3_done", o_done, 1);
    chk("s3_mis",  bus.busy_mismatch, 0);

    // req together with mult in E
    clr();
    cyc(0, 0, 0, 1, MDU_MULT, 0, 1);
    idle(3);
    chk("s4_start", o_start, 0);
    chk("s4_busy",  o_busy, 0);

    // MDU busy while shadow idle
    cyc(0, 0, 0, 0, 0, 0, 0, 1'b1);
    idle(3);
    chk("s5_mis", bus.busy_mismatch, 1);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("s5_clr", bus.busy_mismatch, 0);

    // two back-to-back mult/mflo pairs
    cyc(1, 0, 0, 0, 0, 0, 0);
    clr();
    repeat (2) begin
      cyc(0, 1, MDU_MFLO, 1, MDU_MULT, 0, 0);
      repeat (5) cyc(0, 1, MDU_MFLO, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, MDU_MFLO, 0, 0);
    end
    chk("s6_stall", o_stall, 12);
`ifdef MDU_PERF_CNT_EN
    chk("s6_perf", perf, 12);
`endif

    // random traffic; starts only when the pipe would allow them
    for (int i = 0; i < 400; i++) begin
      bit rs, dv, ev, hd, rq;
      logic [3:0] dop, eop;
      rs  = ($urandom % 60) == 0;
      dv  = 1'($urandom);
      ev  = 1'($urandom);
      hd  = 1'($urandom);
      rq  = ($urandom % 8) == 0;
      dop = 4'($urandom);
      eop = 4'($urandom);
      if (eop >= 5 && eop <= 8 && (m_rem > 0 || m_mdu > 0))
        eop = 4'($urandom_range(0, 4));
      cyc(rs, dv, dop, ev, eop, hd, rq);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
